// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: EX/MEM inputs, MEM/WB outputs and stall of the memory stage
//   master: upstream/driver side; slave: the mem_wb_stage itself
interface mem_wb_stage_if;
  logic [31:0] InstructionIn;
  logic [31:0] ALUResultIn;
  logic [31:0] ReadData2In;
  logic [31:0] WriteRegisterIn;
  logic [1:0] MemWriteIn;
  logic [1:0] MemReadIn;
  logic RegWriteIn;
  logic MemToRegIn;
  logic MemStall;
  logic [31:0] InstructionOut;
  logic [31:0] ALUResultOut;
  logic [31:0] ReadDataOut;
  logic [31:0] WriteRegisterOut;
  logic RegWriteOut;
  logic MemToRegOut;
  modport master (
    output InstructionIn, ALUResultIn, ReadData2In, WriteRegisterIn, MemWriteIn, MemReadIn, RegWriteIn, MemToRegIn,
    input MemStall, InstructionOut, ALUResultOut, ReadDataOut, WriteRegisterOut, RegWriteOut, MemToRegOut
  );
  modport slave (
    input InstructionIn, ALUResultIn, ReadData2In, WriteRegisterIn, MemWriteIn, MemReadIn, RegWriteIn, MemToRegIn,
    output MemStall, InstructionOut, ALUResultOut, ReadDataOut, WriteRegisterOut, RegWriteOut, MemToRegOut
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data memory access with configurable latency, driving the MEM/WB register
//   Clock/Reset: pipeline clock, async active-low reset
//   bus (slave): EX/MEM fields in, MemStall and registered MEM/WB fields out
module mem_wb_stage #(
  parameter int MEM_DEPTH = 1024,
  parameter int MEM_LATENCY = 2
) (
  input logic Clock,
  input logic Reset,
  mem_wb_stage_if.slave bus
);
  localparam int AW = $clog2(MEM_DEPTH);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [3:0] count, count_nx;
  logic [31:0] mem [MEM_DEPTH];
  logic [AW-1:0] idx;
  logic [1:0] lane;
  logic is_op, done, load_out, wr;
  logic [3:0] be;
  logic [31:0] wdata, rword, rdata;
  logic [15:0] rhalf;
  logic [7:0] rbyte;
  assign idx = bus.ALUResultIn[AW+1:2];
  assign lane = bus.ALUResultIn[1:0];
  assign is_op = |bus.MemReadIn || |bus.MemWriteIn;
  always_comb begin
    state_nx = state;
    count_nx = count;
    done = 1'b0;
    bus.MemStall = 1'b0;
    if (state == IDLE) begin
      if (is_op && MEM_LATENCY > 1) begin
        state_nx = BUSY;
        count_nx = 4'(MEM_LATENCY - 1);
        bus.MemStall = Reset;
      end else done = is_op;
    end else if (count > 4'd1) begin
      count_nx = count - 4'd1;
      bus.MemStall = Reset;
    end else begin
      state_nx = IDLE;
      count_nx = 4'd0;
      done = 1'b1;
    end
  end
  // MEM/WB takes the real fields only when nothing is in flight or the op completes; otherwise a bubble
  assign load_out = (state == IDLE && !is_op) || done;
  assign wr = done && |bus.MemWriteIn;
  assign be = bus.MemWriteIn == 2'b01 ? 4'hf :
              bus.MemWriteIn == 2'b10 ? (lane[1] ? 4'hc : 4'h3) : 4'b0001 << lane;
  assign wdata = bus.MemWriteIn == 2'b01 ? bus.ReadData2In :
                 bus.MemWriteIn == 2'b10 ? {2{bus.ReadData2In[15:0]}} : {4{bus.ReadData2In[7:0]}};
  always_ff @(posedge Clock)
    if (wr)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  assign rword = mem[idx];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rdata = |bus.MemWriteIn ? 32'd0 :
                 bus.MemReadIn == 2'b01 ? rword :
                 bus.MemReadIn == 2'b10 ? {{16{rhalf[15]}}, rhalf} :
                 bus.MemReadIn == 2'b11 ? {{24{rbyte[7]}}, rbyte} : 32'd0;
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      state <= IDLE;
      count <= 4'd0;
      bus.InstructionOut <= '0;
      bus.ALUResultOut <= '0;
      bus.ReadDataOut <= '0;
      bus.WriteRegisterOut <= '0;
      bus.RegWriteOut <= 1'b0;
      bus.MemToRegOut <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      bus.InstructionOut <= load_out ? bus.InstructionIn : '0;
      bus.ALUResultOut <= load_out ? bus.ALUResultIn : '0;
      bus.ReadDataOut <= load_out ? rdata : '0;
      bus.WriteRegisterOut <= load_out ? bus.WriteRegisterIn : '0;
      bus.RegWriteOut <= load_out && bus.RegWriteIn;
      bus.MemToRegOut <= load_out && bus.MemToRegIn;
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage placed directly downstream of the EX/MEM pipeline register.
- Contains the data memory and performs word, half and byte loads and stores, with loads sign-extended.
- Drives the MEM/WB pipeline register outputs that feed write-back.
- Supports a configurable multi-cycle memory latency and raises a stall towards upstream stages while an access is in flight.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit data memory words (power of two).
- MEM_LATENCY, 2, cycles a memory operation occupies the stage; legal values 1 to 15.

Ports:
- Clock  input  1  pipeline clock; all state updates on the rising edge.
- Reset  input  1  asynchronous reset, active-low.
- InstructionIn  input  32  instruction from EX/MEM.
- ALUResultIn  input  32  effective address for memory ops; result pass-through otherwise.
- ReadData2In  input  32  store data.
- WriteRegisterIn  input  32  destination register from EX/MEM.
- MemWriteIn  input  2  store size: 00 none, 01 word, 10 half, 11 byte.
- MemReadIn  input  2  load size: same encoding as MemWriteIn.
- RegWriteIn  input  1  register write enable.
- MemToRegIn  input  1  write-back select.
- MemStall  output  1  high means upstream must hold the EX/MEM contents and the PC.
- InstructionOut  output  32  registered instruction.
- ALUResultOut  output  32  registered ALUResultIn.
- ReadDataOut  output  32  registered, sign-extended load data.
- WriteRegisterOut  output  32  registered destination register.
- RegWriteOut  output  1  registered RegWriteIn.
- MemToRegOut  output  1  registered MemToRegIn.

Behaviour:
- Reset (Reset low, asynchronous): all outputs are 0, FSM is IDLE, Count is 0, and MemStall is 0.
- Memory contents are not reset; in simulation they start at all zeros.
- Addressing: word index = ALUResultIn[log2(MEM_DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo MEM_DEPTH*4. Byte order is little-endian.
- Word op: ALUResultIn[1:0] is ignored.
- Half op: lane chosen by ALUResultIn[1]; ALUResultIn[0] is ignored.
- Byte op: lane chosen by ALUResultIn[1:0].
- Stores: write only the selected lanes, taking data from ReadData2In[7:0] for byte or [15:0] for half. Other lanes are unchanged.
- Loads: select the lane, then sign-extend to 32 bits for half and byte loads.
- A memory op is present when MemReadIn!=0 or MemWriteIn!=0.
- If both are nonzero, the store is performed and ReadDataOut is 0.
- Non-memory instruction: registered in one cycle, ReadDataOut=0, MemStall=0.
- FSM states: IDLE, BUSY; 4-bit counter Count.
- IDLE, no op: MEM/WB outputs load the inputs at the edge.
- IDLE, op, MEM_LATENCY=1: the access completes at this edge and the outputs load. Stays IDLE with MemStall=0.
- IDLE, op, MEM_LATENCY>1: MemStall=1 combinationally. At the edge go to BUSY with Count<=MEM_LATENCY-1. MEM/WB loads a bubble: all outputs 0.
- BUSY, Count>1: MemStall=1. At the edge Count decrements and a bubble is loaded.
- BUSY, Count==1: MemStall=0. At the edge the store is written or the load data is captured, MEM/WB loads the instruction's fields, and the FSM returns to IDLE.
- Net timing: an op occupies MEM_LATENCY cycles, MemStall is high for exactly MEM_LATENCY-1 consecutive cycles, and the result appears on the outputs one cycle after completion.
- Inputs must be held stable by upstream while MemStall=1. The store or read uses the values present in the completion cycle.
- A memory write happens at most once per op, and only at completion.
- Reset during BUSY: the op is aborted with no memory write, the FSM returns to IDLE, and the outputs are zeroed.
- Back-to-back memory ops: the second op is accepted in IDLE the cycle after the first completes. No idle gap is required.
- Load-after-store to the same address in consecutive ops returns the new data.

Test Plan:
- MEM_LATENCY=1, store word 0x11223344 at 0x10, then load word at 0x10 -> ReadDataOut=0x11223344 one cycle after the load cycle; MemStall stays 0 throughout.
- After the above: byte load at 0x11 -> 0x00000033; half load at 0x12 -> 0x00001122. Then store byte 0x80 at 0x13 and byte load at 0x13 -> 0xFFFFFF80; word load at 0x10 -> 0x80223344.
- MEM_LATENCY=3, word load held stable -> MemStall high exactly 2 cycles; two bubble cycles on the outputs (RegWriteOut=0); data valid on the 3rd edge.
- Non-memory instruction with ALUResultIn=0xDEADBEEF, RegWriteIn=1, WriteRegisterIn=5 -> next cycle ALUResultOut=0xDEADBEEF, RegWriteOut=1, WriteRegisterOut=5, ReadDataOut=0.
- MEM_LATENCY=3, store word 0xCAFEBABE at 0x20, Reset pulsed low in the 2nd cycle -> outputs immediately 0, MemStall=0. A later load at 0x20 returns the old value (0).
- Address wrap: MEM_DEPTH=1024, store word 0xA5A5A5A5 at 0x1000, load at 0x0 -> 0xA5A5A5A5.
